// File: rtl/aes_keyexp_ctrl_if.sv
// Handshake, key-load and round-key read signals between the key-expansion controller
// and its neighbours.
interface aes_keyexp_ctrl_if;
    logic         start;
    logic [255:0] key_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    modport master (
        output start, key_in, rk_idx,
        input  ready, busy, done, keys_valid, rk_out
    );

    modport slave (
        input  start, key_in, rk_idx,
        output ready, busy, done, keys_valid, rk_out
    );
endinterface

// File: rtl/aes_keyexp_ctrl.sv
// CryptoNight key expansion: four genkey steps (rcon 1, 2, 4, 8) turn a 256-bit key into
// round keys rk0..rk9, held in a bank behind a registered read port.
module aes_keyexp_ctrl #(
    parameter int STEP_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    aes_keyexp_ctrl_if.slave bus
);
    // Byte b of the table lives at bits [8*(255-b) +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [1:0] LAT_LAST = 2'(STEP_LAT - 1);

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t       state, state_nxt;
    logic [1:0]   step, step_nxt;
    logic [1:0]   lat, lat_nxt;
    logic         load, write_step, done_nxt, done_q;
    logic [127:0] rk [10];
    logic [127:0] rk_rd_p1;
    logic [127:0] xin0, xin2, xout0, xout2;
    logic [3:0]   rcon;
    logic [3:0]   rd_base, wr_base;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Word 0 is the top 32 bits; each word absorbs the XOR of every word before it.
    function automatic logic [127:0] prefix_xor(input logic [127:0] x);
        logic [31:0] w0, w1, w2, w3;
        w0 = x[127:96];
        w1 = w0 ^ x[95:64];
        w2 = w1 ^ x[63:32];
        w3 = w2 ^ x[31:0];
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [255:0] aes_genkey_sub(input logic [127:0] x0,
                                                    input logic [127:0] x2,
                                                    input logic [3:0]   rc);
        logic [31:0]  t0, t2;
        logic [127:0] y0, y2;
        t0 = sub_word({x2[23:0], x2[31:24]}) ^ {4'h0, rc, 24'h0};
        y0 = prefix_xor(x0) ^ {4{t0}};
        t2 = sub_word(y0[31:0]);
        y2 = prefix_xor(x2) ^ {4{t2}};
        return {y0, y2};
    endfunction

    assign rd_base = {1'b0, step, 1'b0};
    assign wr_base = rd_base + 4'd2;
    assign xin0    = rk[rd_base];
    assign xin2    = rk[rd_base + 4'd1];
    assign rcon    = 4'b0001 << step;
    assign {xout0, xout2} = aes_genkey_sub(xin0, xin2, rcon);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            step   <= '0;
            lat    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            step   <= step_nxt;
            lat    <= lat_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        step_nxt   = step;
        lat_nxt    = lat;
        load       = 1'b0;
        write_step = 1'b0;
        done_nxt   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    step_nxt  = '0;
                    lat_nxt   = '0;
                    state_nxt = STEP;
                end
            end
            STEP: begin
                if (lat == LAT_LAST) begin
                    write_step = 1'b1;
                    lat_nxt    = '0;
                    if (step == 2'd3) begin
                        step_nxt  = '0;
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        step_nxt = step + 2'd1;
                    end
                end else begin
                    lat_nxt = lat + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ready      = (state != STEP);
    assign bus.busy       = (state == STEP);
    assign bus.done       = done_q;
    assign bus.keys_valid = (state == DONE);
    assign bus.rk_out     = rk_rd_p1;

    // Read stage: bank sampled before this edge's writes land.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 10; i++) rk[i] <= '0;
            rk_rd_p1 <= '0;
        end else begin
            rk_rd_p1 <= (bus.rk_idx < 4'd10) ? rk[bus.rk_idx] : '0;
            if (load) begin
                rk[0] <= bus.key_in[127:0];
                rk[1] <= bus.key_in[255:128];
            end else if (write_step) begin
                rk[wr_base]        <= xout0;
                rk[wr_base + 4'd1] <= xout2;
            end
        end
    end
endmodule

// File: tb/tb_aes_keyexp_ctrl.sv
// Directed bench: three controllers (STEP_LAT 1, 2, 4) checked against a word-wise
// AES-256 key schedule built on a computed S-box.
module tb_aes_keyexp_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         start_v  [3];
    logic [255:0] key_v    [3];
    logic [3:0]   idx_v    [3];
    logic [2:0]   ready_v, busy_v, done_v, kv_v;
    logic [127:0] rk_out_v [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_keyexp_ctrl_if bus ();
        assign bus.start   = start_v[g];
        assign bus.key_in  = key_v[g];
        assign bus.rk_idx  = idx_v[g];
        assign ready_v[g]  = bus.ready;
        assign busy_v[g]   = bus.busy;
        assign done_v[g]   = bus.done;
        assign kv_v[g]     = bus.keys_valid;
        assign rk_out_v[g] = bus.rk_out;
        aes_keyexp_ctrl #(.STEP_LAT(1 << g)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    end

    int           checks, errors;
    logic [7:0]   sb [256];
    logic [127:0] exp_rk [10];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
            sb[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic model(input logic [255:0] key);
        logic [31:0] w [40];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            w[i]     = key[127 - 32*i -: 32];
            w[i + 4] = key[255 - 32*i -: 32];
        end
        for (int i = 8; i < 40; i++) begin
            t = w[i-1];
            if (i % 8 == 0) t = subw({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
            else if (i % 8 == 4) t = subw(t);
            w[i] = w[i-8] ^ t;
        end
        for (int j = 0; j < 10; j++) exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    function automatic logic [255:0] rnd_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Index 0..9 back-to-back, then 12; each result lands exactly one cycle later.
    task automatic sweep(input int d, input string tag);
        for (int i = 0; i <= 11; i++) begin
            @(posedge clk); #1;
            if (i <= 10) idx_v[d] = (i == 10) ? 4'd12 : 4'(i);
            @(negedge clk);
            if (i >= 1) chk({tag, "/rk"}, rk_out_v[d], (i == 11) ? 128'h0 : exp_rk[i-1]);
        end
    endtask

    task automatic read_rk(input int d, input logic [3:0] i, output logic [127:0] v);
        @(posedge clk); #1; idx_v[d] = i;
        @(posedge clk); @(negedge clk); v = rk_out_v[d];
    endtask

    // Called in cycle 0 of an accepted start; watches cycles 1..4L+8.
    task automatic track(input int d, input bit toggle, output int dcyc, output int bcnt,
                         output int dcnt, output logic kv1);
        int lim;
        lim = 4 * (1 << d);
        dcyc = -1; bcnt = 0; dcnt = 0; kv1 = 1'bx;
        for (int c = 1; c <= lim + 8; c++) begin
            @(posedge clk); #1;
            start_v[d] = toggle && (c <= lim);
            key_v[d]   = toggle ? rnd_key() : ~key_v[d];
            @(negedge clk);
            if (c == 1) kv1 = kv_v[d];
            bcnt += int'(busy_v[d]);
            if (done_v[d]) begin
                dcnt++;
                if (dcyc < 0) dcyc = c;
            end
        end
    endtask

    task automatic run_one(input int d, input logic [255:0] key, input bit toggle, input string tag);
        int L, dcyc, bcnt, dcnt;
        logic kv1;
        L = 1 << d;
        @(posedge clk); #1; start_v[d] = 1'b1; key_v[d] = key;
        @(negedge clk); chk({tag, "/ready"}, ready_v[d], 1);
        track(d, toggle, dcyc, bcnt, dcnt, kv1);
        chk({tag, "/busy_cycles"}, bcnt, 4*L);
        chk({tag, "/done_cycle"}, dcyc, 4*L + 1);
        chk({tag, "/done_count"}, dcnt, 1);
        chk({tag, "/kv_after_start"}, kv1, 0);
        chk({tag, "/kv_level"}, kv_v[d], 1);
        model(key);
        sweep(d, tag);
    endtask

    task automatic back_to_back(input int d, input logic [255:0] ka, input logic [255:0] kb);
        int L, dcyc, bcnt, dcnt, waited;
        logic kv1;
        L = 1 << d;
        @(posedge clk); #1; start_v[d] = 1'b1; key_v[d] = ka;
        @(posedge clk); #1; start_v[d] = 1'b0;
        waited = 1;
        while (!done_v[d] && waited < 4*L + 4) begin
            @(posedge clk); #1; waited++;
        end
        chk("b2b/first_done", waited, 4*L + 1);
        start_v[d] = 1'b1; key_v[d] = kb;
        @(negedge clk); chk("b2b/kv_in_done", kv_v[d], 1);
        track(d, 1'b0, dcyc, bcnt, dcnt, kv1);
        chk("b2b/kv_drop", kv1, 0);
        chk("b2b/second_done", dcyc, 4*L + 1);
        chk("b2b/done_count", dcnt, 1);
        chk("b2b/busy_cycles", bcnt, 4*L);
        model(kb);
        sweep(d, "b2b");
    endtask

    task automatic reset_mid(input int d, input logic [255:0] key);
        int L, dn, kvs;
        L = 1 << d;
        @(posedge clk); #1; start_v[d] = 1'b1; key_v[d] = key;
        for (int c = 1; c <= 2*L + 1; c++) begin
            @(posedge clk); #1; start_v[d] = 1'b0;
        end
        @(negedge clk); chk("rst/busy_step2", busy_v[d], 1);
        rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("rst/ready", ready_v[d], 1);
        chk("rst/busy", busy_v[d], 0);
        chk("rst/kv", kv_v[d], 0);
        dn = 0; kvs = 0;
        for (int c = 0; c < 4*L + 4; c++) begin
            @(negedge clk);
            dn += int'(done_v[d]);
            kvs += int'(kv_v[d]);
        end
        chk("rst/no_done", dn, 0);
        chk("rst/kv_stays_low", kvs, 0);
        for (int j = 0; j < 10; j++) exp_rk[j] = '0;
        sweep(d, "rst");
    endtask

    initial begin
        logic [127:0] v;
        logic [255:0] ka;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0; key_v[d] = '0; idx_v[d] = '0;
        end
        build_sbox();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset/ready", ready_v[d], 1);
            chk("reset/busy", busy_v[d], 0);
            chk("reset/done", done_v[d], 0);
            chk("reset/kv", kv_v[d], 0);
            chk("reset/rk_out", rk_out_v[d], 0);
        end

        run_one(0, '0, 1'b0, "zero");
        read_rk(0, 4'd2, v); chk("zero/rk2", v, {4{32'h62636363}});
        read_rk(0, 4'd3, v); chk("zero/rk3", v, {4{32'haafbfbfb}});
        read_rk(0, 4'd4, v); chk("zero/rk4", v, {2{64'h6f6c6ccf0d0f0fac}});
        read_rk(0, 4'd5, v); chk("zero/rk5", v, {2{64'h7d8d8d6ad7767691}});
        read_rk(0, 4'd12, v); chk("zero/rk12", v, 0);

        for (int k = 0; k < 50; k++) begin
            ka = rnd_key();
            for (int d = 0; d < 3; d++) run_one(d, ka, 1'b0, "rand");
        end

        for (int d = 0; d < 3; d++) run_one(d, rnd_key(), 1'b1, "hold");

        reset_mid(0, rnd_key());
        run_one(0, rnd_key(), 1'b0, "after_rst");
        reset_mid(2, rnd_key());
        run_one(2, rnd_key(), 1'b0, "after_rst");

        for (int d = 0; d < 3; d++) back_to_back(d, rnd_key(), rnd_key());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
